// File: rtl/pe_array_feeder.sv
// pe_array_feeder: job sequencer and skew feeder for the weight-stationary N x N INT8 PE array.
// Each job clears the accumulators, loads N weight columns, waits for the load wavefront
// to cross the array, then streams K activation vectors with a one-cycle-per-row skew.
module pe_array_feeder #(
    parameter int unsigned N  = 14,
    parameter int unsigned KW = 16
) (
    input  logic             i_clk,
    input  logic             i_rst_n,
    input  logic             i_start,
    input  logic [KW-1:0]    i_k_len,
    input  logic             i_w_valid,
    output logic             o_w_ready,
    input  logic [N*8-1:0]   i_w_data,
    input  logic             i_a_valid,
    output logic             o_a_ready,
    input  logic [N*8-1:0]   i_a_data,
    output logic             o_pe_clr,
    output logic             o_pe_load_weight,
    output logic [N*8-1:0]   o_pe_b,
    output logic [N*8-1:0]   o_pe_a,
    output logic [N-1:0]     o_pe_en,
    output logic             o_busy,
    output logic             o_done
);

    // Column / wait / drain counter width; one counter serves all N-length phases.
    localparam int unsigned   CW       = (N > 1) ? $clog2(N) : 1;
    localparam logic [CW-1:0] LAST_IDX = CW'(N - 1);

    typedef enum logic [2:0] {
        S_IDLE     = 3'd0,
        S_CLEAR    = 3'd1,
        S_LOAD     = 3'd2,
        S_WAIT_WGT = 3'd3,
        S_STREAM   = 3'd4,
        S_DRAIN    = 3'd5,
        S_DONE     = 3'd6
    } state_t;

    state_t          r_state;
    logic [KW-1:0]   r_k_len;
    logic [KW-1:0]   r_beat_cnt;
    logic [CW-1:0]   r_tmr;
    logic            r_w_ready;
    logic            r_a_ready;
    logic            r_pe_clr;
    logic            r_pe_load_weight;
    logic [N*8-1:0]  r_pe_b;
    logic            r_busy;
    logic            r_done;

    logic            w_w_acc;
    logic            w_a_acc;

    // Handshakes: ready is only ever raised in the phase that consumes that stream.
    assign w_w_acc = r_w_ready & i_w_valid;
    assign w_a_acc = r_a_ready & i_a_valid;

    // Job sequencer with registered control outputs; strobes default low every cycle.
    always_ff @(posedge i_clk) begin
        if (!i_rst_n) begin
            r_state          <= S_IDLE;
            r_k_len          <= '0;
            r_beat_cnt       <= '0;
            r_tmr            <= '0;
            r_w_ready        <= 1'b0;
            r_a_ready        <= 1'b0;
            r_pe_clr         <= 1'b0;
            r_pe_load_weight <= 1'b0;
            r_pe_b           <= '0;
            r_busy           <= 1'b0;
            r_done           <= 1'b0;
        end else begin
            r_pe_clr         <= 1'b0;
            r_pe_load_weight <= 1'b0;
            r_done           <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    if (i_start) begin
                        r_k_len  <= i_k_len;
                        r_pe_clr <= 1'b1;
                        r_busy   <= 1'b1;
                        r_state  <= S_CLEAR;
                    end
                end
                S_CLEAR: begin
                    r_tmr     <= '0;
                    r_w_ready <= 1'b1;
                    r_state   <= S_LOAD;
                end
                S_LOAD: begin
                    if (w_w_acc) begin
                        r_pe_load_weight <= 1'b1;
                        r_pe_b           <= i_w_data;
                        if (r_tmr == LAST_IDX) begin
                            r_tmr     <= '0;
                            r_w_ready <= 1'b0;
                            r_state   <= S_WAIT_WGT;
                        end else begin
                            r_tmr <= r_tmr + CW'(1);
                        end
                    end
                end
                S_WAIT_WGT: begin
                    // N quiet cycles let the last load strobe reach column N-1.
                    if (r_tmr == LAST_IDX) begin
                        r_tmr      <= '0;
                        r_beat_cnt <= '0;
                        if (r_k_len == '0) begin
                            r_state <= S_DRAIN;
                        end else begin
                            r_a_ready <= 1'b1;
                            r_state   <= S_STREAM;
                        end
                    end else begin
                        r_tmr <= r_tmr + CW'(1);
                    end
                end
                S_STREAM: begin
                    if (w_a_acc) begin
                        if (r_beat_cnt == (r_k_len - KW'(1))) begin
                            r_beat_cnt <= '0;
                            r_a_ready  <= 1'b0;
                            r_state    <= S_DRAIN;
                        end else begin
                            r_beat_cnt <= r_beat_cnt + KW'(1);
                        end
                    end
                end
                S_DRAIN: begin
                    // N cycles flush the deepest skew row (N stages).
                    if (r_tmr == LAST_IDX) begin
                        r_tmr   <= '0;
                        r_done  <= 1'b1;
                        r_state <= S_DONE;
                    end else begin
                        r_tmr <= r_tmr + CW'(1);
                    end
                end
                S_DONE: begin
                    r_busy  <= 1'b0;
                    r_state <= S_IDLE;
                end
                default: begin
                    r_state <= S_IDLE;
                end
            endcase
        end
    end

    // Per-row skew: row r is an (r+1)-deep shift register of {en, act}; bubbles inject zeros.
    for (genvar r = 0; r < N; r++) begin : g_row
        logic [r:0][7:0] r_sk_a;
        logic [r:0]      r_sk_en;

        // Shift one stage per cycle; stage 0 takes the accepted beat or a zero bubble.
        always_ff @(posedge i_clk) begin
            if (!i_rst_n) begin
                r_sk_a  <= '0;
                r_sk_en <= '0;
            end else begin
                r_sk_a[0]  <= w_a_acc ? i_a_data[8*r +: 8] : 8'h00;
                r_sk_en[0] <= w_a_acc;
                for (int s = 1; s <= r; s++) begin
                    r_sk_a[s]  <= r_sk_a[s-1];
                    r_sk_en[s] <= r_sk_en[s-1];
                end
            end
        end

        assign o_pe_a[8*r +: 8] = r_sk_a[r];
        assign o_pe_en[r]       = r_sk_en[r];
    end

    assign o_w_ready        = r_w_ready;
    assign o_a_ready        = r_a_ready;
    assign o_pe_clr         = r_pe_clr;
    assign o_pe_load_weight = r_pe_load_weight;
    assign o_pe_b           = r_pe_b;
    assign o_busy           = r_busy;
    assign o_done           = r_done;

endmodule

// File: tb/tb_pe_array_feeder.sv
// Testbench for pe_array_feeder (N=4): directed and randomized jobs against a
// timestamp-based reference model of the job phases and the skewed West-edge stream.
module tb_pe_array_feeder;

    localparam int unsigned N  = 4;
    localparam int unsigned KW = 16;

    logic            clk;
    logic            i_rst_n;
    logic            i_start;
    logic [KW-1:0]   i_k_len;
    logic            i_w_valid;
    logic            o_w_ready;
    logic [N*8-1:0]  i_w_data;
    logic            i_a_valid;
    logic            o_a_ready;
    logic [N*8-1:0]  i_a_data;
    logic            o_pe_clr;
    logic            o_pe_load_weight;
    logic [N*8-1:0]  o_pe_b;
    logic [N*8-1:0]  o_pe_a;
    logic [N-1:0]    o_pe_en;
    logic            o_busy;
    logic            o_done;

    int checks;
    int errors;

    // Per-job statistics and traces gathered by run_job, indexed by sample number
    // (sample 0 is the cycle right after the start edge, i.e. the CLEAR cycle).
    int    st_bad, st_clr, st_clr_e, st_lw, st_ovl, st_done, st_done_e, st_ardy, st_bub;
    int    st_timeout, st_aborted;
    int    st_en [N];
    string st_msg;

    logic [N*8-1:0] m_a  [int];
    logic [N-1:0]   m_en [int];
    logic [N*8-1:0] m_b  [int];
    logic [N*8-1:0] tr_a [int];
    logic [N*8-1:0] tr_b [int];
    logic [N-1:0]   tr_en[int];
    logic           tr_lw[int];

    pe_array_feeder #(.N(N), .KW(KW)) dut (
        .i_clk            (clk),
        .i_rst_n          (i_rst_n),
        .i_start          (i_start),
        .i_k_len          (i_k_len),
        .i_w_valid        (i_w_valid),
        .o_w_ready        (o_w_ready),
        .i_w_data         (i_w_data),
        .i_a_valid        (i_a_valid),
        .o_a_ready        (o_a_ready),
        .i_a_data         (i_a_data),
        .o_pe_clr         (o_pe_clr),
        .o_pe_load_weight (o_pe_load_weight),
        .o_pe_b           (o_pe_b),
        .o_pe_a           (o_pe_a),
        .o_pe_en          (o_pe_en),
        .o_busy           (o_busy),
        .o_done           (o_done)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    function automatic logic [N*8-1:0] rand_vec();
        logic [N*8-1:0] v;
        for (int i = 0; i < N; i++) v[8*i +: 8] = 8'($urandom_range(255));
        return v;
    endfunction

    // Directed weight column c: weights 1..N*N laid out column by column.
    function automatic logic [N*8-1:0] dir_w(input int c);
        logic [N*8-1:0] v;
        for (int r = 0; r < N; r++) v[8*r +: 8] = 8'(N * c + r + 1);
        return v;
    endfunction

    // Directed activation beat b (1-based): row r carries (r+1)*b.
    function automatic logic [N*8-1:0] dir_a(input int b);
        logic [N*8-1:0] v;
        for (int r = 0; r < N; r++) v[8*r +: 8] = 8'((r + 1) * b);
        return v;
    endfunction

    function automatic bit all_out_zero();
        return ({o_w_ready, o_a_ready, o_pe_clr, o_pe_load_weight, o_busy, o_done} === '0) &&
               (o_pe_a === '0) && (o_pe_b === '0) && (o_pe_en === '0);
    endfunction

    // Drive one job and compare every cycle against the model. Phase boundaries are derived
    // from acceptance timestamps: last weight at tl -> stream from tl+N; last beat (or tl+N
    // when k=0) at tdr -> done at tdr+N. Beat accepted at edge e shows on row r at sample e+r.
    task automatic run_job(input int k, input int stall, input bit dir,
                           input int abort_beat, input bit spur);
        int e, nload, nact, tl, tdr, tdone;
        bit wr, ar, aborted;
        logic e_clr, e_busy, e_done, e_wr, e_ar, e_lw;
        logic [N*8-1:0] e_a, tmp_a;
        logic [N-1:0]   e_en, tmp_en;
        m_a.delete(); m_en.delete(); m_b.delete();
        tr_a.delete(); tr_b.delete(); tr_en.delete(); tr_lw.delete();
        st_bad = 0; st_msg = ""; st_clr = 0; st_clr_e = -1; st_lw = 0; st_ovl = 0;
        st_done = 0; st_done_e = -1; st_ardy = 0; st_bub = 0; st_timeout = 0; st_aborted = 0;
        for (int r = 0; r < N; r++) st_en[r] = 0;
        i_start = 1'b1; i_k_len = KW'(k); i_w_valid = 1'b0; i_a_valid = 1'b0;
        e = -1; nload = 0; nact = 0; tl = -1; tdr = -1; tdone = -1; aborted = 1'b0;
        forever begin
            wr = (e >= 1) && (nload < N);
            ar = (tl >= 0) && (e >= tl + N) && (nact < k);
            if (e >= 0) begin
                i_w_valid = ($urandom_range(99) >= stall);
                i_w_data  = dir ? dir_w(nload) : rand_vec();
                i_a_valid = ($urandom_range(99) >= stall);
                i_a_data  = dir ? dir_a(nact + 1) : rand_vec();
                if (spur && (e == 2 || (tdr >= 0 && e == tdr + 1))) i_start = 1'b1;
                if (abort_beat > 0 && ar && nact == abort_beat - 1) begin
                    i_rst_n = 1'b0; i_a_valid = 1'b1; aborted = 1'b1;
                end
            end
            @(posedge clk); #1;
            i_start = 1'b0;
            if (aborted) begin
                i_rst_n = 1'b1; i_w_valid = 1'b0; i_a_valid = 1'b0; st_aborted = 1;
                return;
            end
            e++;
            if (i_w_valid && wr) begin
                m_b[e] = i_w_data;
                nload++;
                if (nload == N) tl = e;
            end
            if (i_a_valid && ar) begin
                for (int r = 0; r < N; r++) begin
                    tmp_a  = m_a.exists(e + r)  ? m_a[e + r]  : '0;
                    tmp_en = m_en.exists(e + r) ? m_en[e + r] : '0;
                    tmp_a[8*r +: 8] = i_a_data[8*r +: 8];
                    tmp_en[r] = 1'b1;
                    m_a[e + r] = tmp_a; m_en[e + r] = tmp_en;
                end
                nact++;
                if (nact == k) tdr = e;
            end
            if (tl >= 0 && k == 0) tdr = tl + N;
            if (tdr >= 0) tdone = tdr + N;
            e_clr  = (e == 0);
            e_busy = (tdone < 0) || (e <= tdone);
            e_done = (e == tdone);
            e_wr   = (e >= 1) && (nload < N);
            e_ar   = (tl >= 0) && (e >= tl + N) && (nact < k);
            e_lw   = m_b.exists(e);
            e_a    = m_a.exists(e)  ? m_a[e]  : '0;
            e_en   = m_en.exists(e) ? m_en[e] : '0;
            if ({o_pe_clr, o_busy, o_done, o_w_ready, o_a_ready, o_pe_load_weight} !==
                    {e_clr, e_busy, e_done, e_wr, e_ar, e_lw} ||
                o_pe_a !== e_a || o_pe_en !== e_en || (e_lw && o_pe_b !== m_b[e])) begin
                if (st_bad == 0)
                    st_msg = $sformatf("sample %0d clr/busy/done/wrdy/ardy/lw=%b want %b pe_a=%h want %h pe_en=%b want %b pe_b=%h",
                        e, {o_pe_clr, o_busy, o_done, o_w_ready, o_a_ready, o_pe_load_weight},
                        {e_clr, e_busy, e_done, e_wr, e_ar, e_lw}, o_pe_a, e_a, o_pe_en, e_en, o_pe_b);
                st_bad++;
            end
            tr_a[e] = o_pe_a; tr_b[e] = o_pe_b; tr_en[e] = o_pe_en; tr_lw[e] = o_pe_load_weight;
            if (o_pe_clr) begin st_clr++; if (st_clr_e < 0) st_clr_e = e; end
            if (o_done) begin st_done++; st_done_e = e; end
            st_lw   += int'(o_pe_load_weight);
            st_ovl  += int'(o_pe_load_weight && (|o_pe_en));
            st_ardy += int'(o_a_ready);
            for (int r = 0; r < N; r++) begin
                st_en[r] += int'(o_pe_en[r]);
                if (!o_pe_en[r] && o_pe_a[8*r +: 8] !== 8'h00) st_bub++;
            end
            if (tdone >= 0 && e == tdone + 1) return;
            if (e > 3000) begin st_timeout = 1; return; end
        end
    endtask

    task automatic test_reset();
        i_rst_n = 1'b0; i_start = 1'b0; i_k_len = '0;
        i_w_valid = 1'b0; i_a_valid = 1'b0; i_w_data = '0; i_a_data = '0;
        repeat (3) @(posedge clk);
        #1;
        checks++;
        if (!all_out_zero()) begin
            errors++;
            $display("FAIL reset_outputs: pe_a=%h pe_b=%h pe_en=%b ctl=%b required all zero",
                     o_pe_a, o_pe_b, o_pe_en,
                     {o_w_ready, o_a_ready, o_pe_clr, o_pe_load_weight, o_busy, o_done});
        end
        i_rst_n = 1'b1;
        @(posedge clk); #1;
        checks++;
        if (o_busy !== 1'b0 || o_done !== 1'b0) begin
            errors++;
            $display("FAIL reset_idle: busy=%b done=%b required 0 0", o_busy, o_done);
        end
    endtask

    task automatic test_nominal();
        int quiet;
        logic [7:0] got;
        run_job(3, 0, 1'b1, 0, 1'b0);
        checks++;
        if (st_bad !== 0 || st_timeout !== 0) begin
            errors++;
            $display("FAIL nominal_model: %0d bad cycles timeout=%0d first: %s", st_bad, st_timeout, st_msg);
        end
        checks++;
        if (st_clr !== 1 || st_clr_e !== 0) begin
            errors++;
            $display("FAIL nominal_clr: count=%0d at sample %0d required 1 at 0", st_clr, st_clr_e);
        end
        checks++;
        if (st_lw !== N) begin
            errors++;
            $display("FAIL nominal_load_count: got %0d required %0d", st_lw, N);
        end
        for (int c = 0; c < N; c++) begin
            checks++;
            if (tr_lw[2 + c] !== 1'b1 || tr_b[2 + c] !== dir_w(c)) begin
                errors++;
                $display("FAIL nominal_column%0d: lw=%b pe_b=%h required 1 %h",
                         c, tr_lw[2 + c], tr_b[2 + c], dir_w(c));
            end
        end
        quiet = 0;
        for (int s = N + 2; s <= 2 * N + 1; s++) quiet += int'(tr_lw[s] || (|tr_en[s]));
        checks++;
        if (quiet !== 0) begin
            errors++;
            $display("FAIL nominal_wait_quiet: %0d active cycles required 0", quiet);
        end
        for (int r = 0; r < N; r++) begin
            for (int b = 1; b <= 3; b++) begin
                got = tr_a[2 * N + 1 + b + r][8*r +: 8];
                checks++;
                if (got !== 8'((r + 1) * b) || tr_en[2 * N + 1 + b + r][r] !== 1'b1) begin
                    errors++;
                    $display("FAIL nominal_skew_r%0d_b%0d: pe_a=%0d en=%b required %0d 1",
                             r, b, got, tr_en[2 * N + 1 + b + r][r], (r + 1) * b);
                end
            end
        end
        checks++;
        if (st_done_e + 1 !== 1 + N + N + 3 + N + 1 || st_done !== 1) begin
            errors++;
            $display("FAIL nominal_done_cycle: cycle %0d count %0d required %0d 1",
                     st_done_e + 1, st_done, 1 + N + N + 3 + N + 1);
        end
    endtask

    task automatic test_random_stalls();
        int k;
        for (int j = 0; j < 4; j++) begin
            k = $urandom_range(10, 1);
            run_job(k, 30, 1'b0, 0, 1'b0);
            checks++;
            if (st_bad !== 0 || st_timeout !== 0) begin
                errors++;
                $display("FAIL stall_model job%0d k=%0d: %0d bad cycles timeout=%0d first: %s",
                         j, k, st_bad, st_timeout, st_msg);
            end
            checks++;
            if (st_lw !== N) begin
                errors++;
                $display("FAIL stall_load_count job%0d: got %0d required %0d", j, st_lw, N);
            end
            for (int r = 0; r < N; r++) begin
                checks++;
                if (st_en[r] !== k) begin
                    errors++;
                    $display("FAIL stall_en_count job%0d row%0d: got %0d required %0d", j, r, st_en[r], k);
                end
            end
            checks++;
            if (st_ovl !== 0 || st_bub !== 0 || st_done !== 1) begin
                errors++;
                $display("FAIL stall_invariants job%0d: overlap=%0d bubble_nonzero=%0d done=%0d required 0 0 1",
                         j, st_ovl, st_bub, st_done);
            end
        end
    endtask

    task automatic test_k_zero();
        int en_sum;
        run_job(0, 0, 1'b0, 0, 1'b0);
        en_sum = 0;
        for (int r = 0; r < N; r++) en_sum += st_en[r];
        checks++;
        if (st_bad !== 0 || st_timeout !== 0) begin
            errors++;
            $display("FAIL kzero_model: %0d bad cycles timeout=%0d first: %s", st_bad, st_timeout, st_msg);
        end
        checks++;
        if (st_ardy !== 0 || en_sum !== 0) begin
            errors++;
            $display("FAIL kzero_no_stream: a_ready cycles=%0d en ones=%0d required 0 0", st_ardy, en_sum);
        end
        checks++;
        if (st_done_e + 1 !== 1 + N + N + N + 1) begin
            errors++;
            $display("FAIL kzero_done_cycle: cycle %0d required %0d", st_done_e + 1, 1 + N + N + N + 1);
        end
    endtask

    task automatic test_reset_midjob();
        int stray;
        run_job(5, 0, 1'b0, 2, 1'b0);
        checks++;
        if (st_aborted !== 1 || st_bad !== 0) begin
            errors++;
            $display("FAIL midreset_reached: aborted=%0d bad=%0d required 1 0 first: %s", st_aborted, st_bad, st_msg);
        end
        checks++;
        if (!all_out_zero()) begin
            errors++;
            $display("FAIL midreset_outputs: pe_a=%h pe_b=%h pe_en=%b ctl=%b required all zero",
                     o_pe_a, o_pe_b, o_pe_en,
                     {o_w_ready, o_a_ready, o_pe_clr, o_pe_load_weight, o_busy, o_done});
        end
        stray = 0;
        repeat (6) begin
            @(posedge clk); #1;
            stray += int'(o_done || o_busy || (|o_pe_en));
        end
        checks++;
        if (stray !== 0) begin
            errors++;
            $display("FAIL midreset_no_done: %0d active cycles required 0", stray);
        end
        run_job(2, 0, 1'b0, 0, 1'b0);
        checks++;
        if (st_bad !== 0 || st_timeout !== 0 || st_done !== 1 || st_clr_e !== 0) begin
            errors++;
            $display("FAIL midreset_clean_job: bad=%0d timeout=%0d done=%0d clr_at=%0d required 0 0 1 0 first: %s",
                     st_bad, st_timeout, st_done, st_clr_e, st_msg);
        end
    endtask

    task automatic test_spurious_start();
        int stray;
        run_job(4, 20, 1'b0, 0, 1'b1);
        checks++;
        if (st_bad !== 0 || st_timeout !== 0 || st_done !== 1 || st_clr !== 1) begin
            errors++;
            $display("FAIL spurious_start_job: bad=%0d timeout=%0d done=%0d clr=%0d required 0 0 1 1 first: %s",
                     st_bad, st_timeout, st_done, st_clr, st_msg);
        end
        stray = 0;
        repeat (5) begin
            @(posedge clk); #1;
            stray += int'(o_busy || o_pe_clr || o_done);
        end
        checks++;
        if (stray !== 0) begin
            errors++;
            $display("FAIL spurious_start_idle: %0d active cycles required 0", stray);
        end
    endtask

    task automatic test_back_to_back();
        run_job(2, 0, 1'b0, 0, 1'b0);
        checks++;
        if (st_bad !== 0 || st_done !== 1) begin
            errors++;
            $display("FAIL b2b_job1: bad=%0d done=%0d required 0 1 first: %s", st_bad, st_done, st_msg);
        end
        run_job(3, 10, 1'b0, 0, 1'b0);
        checks++;
        if (st_clr !== 1 || st_clr_e !== 0) begin
            errors++;
            $display("FAIL b2b_job2_clr: count=%0d at sample %0d required 1 at 0", st_clr, st_clr_e);
        end
        checks++;
        if (st_bad !== 0 || st_ovl !== 0 || st_done !== 1) begin
            errors++;
            $display("FAIL b2b_job2: bad=%0d overlap=%0d done=%0d required 0 0 1 first: %s",
                     st_bad, st_ovl, st_done, st_msg);
        end
    endtask

    initial begin
        checks = 0;
        errors = 0;
        test_reset();
        test_nominal();
        test_random_stalls();
        test_k_zero();
        test_reset_midjob();
        test_spurious_start();
        test_back_to_back();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/pe_array_feeder.md
# pe_array_feeder

Sequencer and skew feeder that drives the control and data inputs of the N×N weight-stationary INT8 PE array. Per job it:
- pulses an accumulator clear;
- streams N weight columns into the array with `load_weight`;
- waits for the systolic `load_weight` wavefront to cross all columns;
- streams K activation vectors, skewed one cycle per row, with matching per-row MAC enables.

It sits between the activation/weight buffers (valid/ready) and the array's West edge.

## Interface
- `N`, 14: array dimension (rows = columns).
- `KW`, 16: width of the activation beat count.
- `clk`  in  1  rising-edge clock.
- `rst_n`  in  1  reset, synchronous, active-low.
- `start`  in  1  one-cycle job request; sampled only in IDLE.
- `k_len`  in  KW  activation beats for the job; captured with `start`.
- `w_valid`  in  1  weight column beat valid.
- `w_ready`  out  1  weight beat accepted when `w_valid && w_ready`.
- `w_data`  in  N*8  one weight column, row r at bits [8r+7:8r], signed.
- `a_valid`  in  1  activation beat valid.
- `a_ready`  out  1  activation beat accepted when `a_valid && a_ready`.
- `a_data`  in  N*8  one activation vector, row r at bits [8r+7:8r], signed.
- `pe_clr`  out  1  accumulator clear to all PEs.
- `pe_load_weight`  out  1  load strobe into column 0; the array propagates it East.
- `pe_b`  out  N*8  weight bytes, valid when `pe_load_weight` = 1.
- `pe_a`  out  N*8  skewed activations to the West edge.
- `pe_en`  out  N  per-row MAC enable, skewed identically to `pe_a`.
- `busy`  out  1  high in every state except IDLE.
- `done`  out  1  one-cycle pulse at job end.

## Operation
- States: IDLE → CLEAR → LOAD → WAIT_WGT → STREAM → DRAIN → DONE → IDLE.
- IDLE
  - `start` = 1: capture `k_len`, go to CLEAR.
  - `start` outside IDLE is ignored.
- CLEAR: one cycle, `pe_clr` = 1.
- LOAD
  - `w_ready` = 1.
  - Each accepted beat: `pe_load_weight` = 1, `pe_b` = `w_data` (registered), column counter increments.
  - `w_valid` = 0: `pe_load_weight` = 0 that cycle, counter holds.
  - After the N-th accepted beat, go to WAIT_WGT.
- WAIT_WGT: exactly N cycles, all strobes low, so the last load wavefront clears column N-1 before any enable.
- STREAM
  - `a_ready` = 1.
  - Each accepted beat enters the skew pipeline with an enable bit of 1.
  - Non-accepted cycles inject activation 0 with enable bit 0 (bubble).
  - After `k_len` accepted beats, go to DRAIN.
  - `k_len` = 0: skip STREAM; WAIT_WGT exits directly to DRAIN.
- DRAIN: N cycles, injecting zeros and enable 0, until the last beat has exited row N-1.
- DONE: `done` = 1 for one cycle, then IDLE.
- Skew pipeline
  - Row r is an (r+1)-stage shift register of {en, act}.
  - `pe_a[r]` / `pe_en[r]` is the beat accepted r+1 cycles earlier.
- Invariants
  - `pe_load_weight` and any `pe_en` bit are never high in the same cycle.
  - `w_ready` and `a_ready` are never both high.
- No arithmetic is performed; bytes pass unmodified.
- `KW`-bit beat counter; `k_len` up to 2^KW−1 is supported, with no wrap inside a job.

## Timing
- All outputs are registered.
- Reset (`rst_n` low at a clock edge):
  - state = IDLE, all counters 0, skew pipeline flushed;
  - `pe_a`, `pe_b`, `pe_en`, `pe_clr`, `pe_load_weight`, `busy`, `done`, `w_ready`, `a_ready` all 0.
  - Reset mid-job abandons the job with no `done`.
- Phase timing, where `start` is sampled at edge T0:
  - CLEAR is the T0+1 cycle, so `pe_clr` is high for that one cycle.
  - LOAD begins the cycle after.
- `pe_load_weight` asserts the cycle after beat acceptance.
- `pe_a[0]` shows a beat 1 cycle after acceptance; `pe_a[N-1]` shows it N cycles after.
- No-stall job length, `start` edge to `done`: 1 + N + N + K + N + 1 cycles (CLEAR, LOAD, WAIT_WGT, STREAM, DRAIN, DONE).
- `busy` is high from the cycle after `start` through the DONE cycle inclusive.
- A new `start` is accepted on the first IDLE cycle after DONE.

## Test plan
- N=4, K=3, no stalls, weights 1..16, activations rows {1,2,3,4}×beat:
  - `pe_clr` exactly once;
  - 4 `pe_load_weight` pulses carrying the columns in order;
  - 4 idle cycles;
  - `pe_a[r]` shows beats 1..3 at cycles r+1..r+3 after acceptance;
  - `done` at cycle 1+4+4+3+4+1 = 17.
- Random `w_valid`/`a_valid` deassertion (~30 %):
  - load pulses count exactly N;
  - `pe_en` ones per row exactly K;
  - zero bubbles carry `pe_en` = 0;
  - never `pe_load_weight && |pe_en`.
- `k_len` = 0: CLEAR, LOAD, WAIT_WGT, DRAIN, DONE; `a_ready` never high; `pe_en` always 0.
- `rst_n` low for 1 cycle during STREAM beat 2 of 5:
  - all outputs 0 next cycle;
  - no `done`;
  - state IDLE;
  - a subsequent `start` runs a clean job.
- `start` pulsed during LOAD and DRAIN: ignored; exactly one `done` per accepted `start`.
- Back-to-back jobs (`start` on the first IDLE cycle after `done`):
  - second job's `pe_clr` is 1 cycle after its `start`;
  - no enable from job 1 overlaps job 2's load phase.
